// File: rtl/ddsm_pkg.sv
// Shared constants and helpers for the MASH delta-sigma modulator core.
package ddsm_pkg;

  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps for x^16+x^14+x^13+x^11+1 in a right-shifting Fibonacci register.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int unsigned DATA_W_MIN = 4;
  localparam int unsigned DATA_W_MAX = 32;
  localparam int unsigned STAGES_MIN = 1;
  localparam int unsigned STAGES_MAX = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ddsm_acc_stage.sv
// One masked accumulator stage: width-B carry extraction, hold/step/load,
// and a combinational new-sum output that feeds the next stage in the same cycle.
module ddsm_acc_stage
  import ddsm_pkg::*;
#(
  parameter int unsigned    P_W       = 24,
  parameter logic [P_W-1:0] P_RST_VAL = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_step,
  input  logic                       i_active,
  input  logic                       i_load,
  input  logic [P_W-1:0]             i_load_val,
  input  logic [P_W-1:0]             i_mask,
  input  logic [clog2(P_W+1)-1:0]    i_bits,
  input  logic [P_W-1:0]             i_add,
  input  logic                       i_cin,
  output logic [P_W-1:0]             o_sum,
  output logic                       o_carry
);

  logic [P_W-1:0] acc_q, acc_d;
  logic [P_W:0]   sum;

  // Operands are re-masked so a shrinking B never lets stale upper bits leak into the carry.
  always_comb begin
    sum     = {1'b0, acc_q & i_mask} + {1'b0, i_add & i_mask} + {{P_W{1'b0}}, i_cin};
    o_carry = i_active & sum[i_bits];
    o_sum   = i_active ? (sum[P_W-1:0] & i_mask) : (acc_q & i_mask);
    acc_d   = acc_q;
    if (i_load) begin
      acc_d = i_load_val & i_mask;
    end else if (i_step) begin
      acc_d = o_sum;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= P_RST_VAL;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/ddsm_mash_core.sv
// MASH delta-sigma modulator: P_STAGES cascaded accumulators with runtime order/width,
// seed load, LFSR dither and a registered digital error-cancellation output.
module ddsm_mash_core
  import ddsm_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 24,
  parameter int unsigned P_STAGES     = 3,
  parameter int unsigned P_SEED_RST   = 0
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_en,
  input  logic [P_DATA_WIDTH-1:0]           i_frac,
  input  logic [clog2(P_DATA_WIDTH+1)-1:0]  i_acc_bits,
  input  logic [2:0]                        i_order,
  input  logic                              i_dither_en,
  input  logic                              i_seed_load,
  input  logic [P_DATA_WIDTH-1:0]           i_seed,
  output logic signed [P_STAGES:0]          o_dsm,
  output logic                              o_valid
);

  localparam int unsigned  BW        = clog2(P_DATA_WIDTH + 1);
  localparam int unsigned  YW        = P_STAGES + 2;
  localparam logic [BW-1:0] BITS_MAX  = BW'(P_DATA_WIDTH);
  localparam logic [2:0]    ORDER_MAX = 3'(P_STAGES);

  logic [BW-1:0]           bits_eff;
  logic [2:0]              order_eff;
  logic [P_DATA_WIDTH-1:0] mask;
  logic                    step;
  logic [LFSR_W-1:0]       lfsr_q, lfsr_d;
  logic [P_STAGES-1:0]     carry_v;
  logic signed [YW-1:0]    e      [P_STAGES];
  logic signed [YW-1:0]    hist_q [1:P_STAGES-1];
  logic signed [YW-1:0]    hist_d [1:P_STAGES-1];
  logic signed [P_STAGES:0] dsm_q, dsm_d;
  logic                    valid_q, valid_d;

  function automatic logic signed [YW-1:0] ext_carry(input logic b);
    return $signed({{(YW-1){1'b0}}, b});
  endfunction

  always_comb begin
    bits_eff  = (i_acc_bits == '0 || i_acc_bits > BITS_MAX) ? BITS_MAX : i_acc_bits;
    order_eff = (i_order == 3'd0 || i_order > ORDER_MAX) ? ORDER_MAX : i_order;
    mask      = ~({P_DATA_WIDTH{1'b1}} << bits_eff);
    step      = i_en & ~i_seed_load;
  end

  for (genvar k = 0; k < P_STAGES; k++) begin : g_stage
    logic [P_DATA_WIDTH-1:0] add;
    logic [P_DATA_WIDTH-1:0] sum;
    logic                    cin;
    logic                    carry;

    if (k == 0) begin : g_head
      assign add = i_frac;
      assign cin = lfsr_q[0] & i_dither_en;
    end else begin : g_tail
      assign add = g_stage[k-1].sum;
      assign cin = 1'b0;
    end

    ddsm_acc_stage #(
      .P_W       (P_DATA_WIDTH),
      .P_RST_VAL ((k == 0) ? P_DATA_WIDTH'(P_SEED_RST) : '0)
    ) u_stage (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_step     (step),
      .i_active   (3'(k) < order_eff),
      .i_load     (i_seed_load),
      .i_load_val ((k == 0) ? i_seed : '0),
      .i_mask     (mask),
      .i_bits     (bits_eff),
      .i_add      (add),
      .i_cin      (cin),
      .o_sum      (sum),
      .o_carry    (carry)
    );

    assign carry_v[k] = carry;
  end

  // Nested form y = c1 + D(c2 + D(c3 + D(c4))); e[0] is the output sample.
  always_comb begin
    e[P_STAGES-1] = ext_carry(carry_v[P_STAGES-1]);
    for (int k = int'(P_STAGES) - 2; k >= 0; k--) begin
      e[k] = ext_carry(carry_v[k]) + e[k+1] - hist_q[k+1];
    end
  end

  always_comb begin
    lfsr_d  = lfsr_q;
    dsm_d   = dsm_q;
    valid_d = 1'b0;
    hist_d  = hist_q;
    if (i_seed_load) begin
      dsm_d = '0;
      for (int k = 1; k < int'(P_STAGES); k++) hist_d[k] = '0;
    end else if (i_en) begin
      lfsr_d  = {^(lfsr_q & LFSR_TAPS), lfsr_q[LFSR_W-1:1]};
      dsm_d   = e[0][P_STAGES:0];
      valid_d = 1'b1;
      for (int k = 1; k < int'(P_STAGES); k++) hist_d[k] = e[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q  <= LFSR_SEED;
      dsm_q   <= '0;
      valid_q <= 1'b0;
      for (int k = 1; k < int'(P_STAGES); k++) hist_q[k] <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      dsm_q   <= dsm_d;
      valid_q <= valid_d;
      for (int k = 1; k < int'(P_STAGES); k++) hist_q[k] <= hist_d[k];
    end
  end

  assign o_dsm   = dsm_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_ddsm_mash_core.sv
// Directed bench for ddsm_mash_core (W=8, three stages) with hand-computed sequences.
module tb_ddsm_mash_core;

  localparam int W = 8;
  localparam int P = 3;

  logic         i_clk       = 1'b0;
  logic         i_rst_n     = 1'b0;
  logic         i_en        = 1'b0;
  logic [W-1:0] i_frac      = '0;
  logic [3:0]   i_acc_bits  = '0;
  logic [2:0]   i_order     = '0;
  logic         i_dither_en = 1'b0;
  logic         i_seed_load = 1'b0;
  logic [W-1:0] i_seed      = '0;
  logic [P:0]   o_dsm;
  logic         o_valid;

  int n_checks = 0;
  int n_errors = 0;
  int exp_seq[$];

  ddsm_mash_core #(
    .P_DATA_WIDTH (W),
    .P_STAGES     (P),
    .P_SEED_RST   (0)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_frac      (i_frac),
    .i_acc_bits  (i_acc_bits),
    .i_order     (i_order),
    .i_dither_en (i_dither_en),
    .i_seed_load (i_seed_load),
    .i_seed      (i_seed),
    .o_dsm       (o_dsm),
    .o_valid     (o_valid)
  );

  always #5 i_clk = ~i_clk;

  function automatic int dsm_s();
    return int'($signed(o_dsm));
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reset with new settings applied, then release with i_en high.
  task automatic restart(input logic [W-1:0] f, input logic [3:0] b, input logic [2:0] k,
                         input logic d);
    @(negedge i_clk);
    i_en        = 1'b0;
    i_seed_load = 1'b0;
    i_rst_n     = 1'b0;
    i_frac      = f;
    i_acc_bits  = b;
    i_order     = k;
    i_dither_en = d;
    #1;
    check("rst_valid", int'(o_valid), 0);
    check("rst_dsm", dsm_s(), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_en    = 1'b1;
  endtask

  task automatic run_expect(input string tag);
    foreach (exp_seq[i]) begin
      @(posedge i_clk);
      #1;
      check($sformatf("%s_valid[%0d]", tag, i), int'(o_valid), 1);
      check($sformatf("%s[%0d]", tag, i), dsm_s(), exp_seq[i]);
    end
  endtask

  initial begin
    int sum;
    int bad;
    int nz;
    int unsigned f;

    // First-order, frac=64: one carry every four steps.
    restart(8'd64, 4'd8, 3'd1, 1'b0);
    exp_seq = {0, 0, 0, 1, 0, 0, 0, 1};
    run_expect("k1_f64");
    @(negedge i_clk);
    i_en = 1'b0;
    @(posedge i_clk);
    #1;
    check("idle_valid", int'(o_valid), 0);
    check("idle_hold", dsm_s(), 1);

    // Second order, frac=128, plus a 400-sample mean.
    restart(8'd128, 4'd8, 3'd2, 1'b0);
    exp_seq = {0, 1, 1, 0, 0, 1, 1, 0};
    run_expect("k2_f128");
    sum = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge i_clk);
      #1;
      sum += dsm_s();
    end
    check("k2_sum400", sum, 200);

    // Narrow accumulator: frac 0xF4 masked to 4 bits gives 4.
    restart(8'hF4, 4'd4, 3'd1, 1'b0);
    exp_seq = {0, 0, 0, 1, 0, 0, 0, 1};
    run_expect("k1_b4");

    // Width clamping: 0 and 15 both mean 8.
    restart(8'd64, 4'd0, 3'd1, 1'b0);
    exp_seq = {0, 0, 0, 1};
    run_expect("bits0");
    restart(8'd64, 4'd15, 3'd1, 1'b0);
    run_expect("bits15");

    // Third order, frac=128, then order clamping 0 and 7 -> 3.
    exp_seq = {0, 2, -1, 1, 0, 2, -1, 1};
    restart(8'd128, 4'd8, 3'd3, 1'b0);
    run_expect("k3_f128");
    restart(8'd128, 4'd8, 3'd0, 1'b0);
    run_expect("ord0");
    restart(8'd128, 4'd8, 3'd7, 1'b0);
    run_expect("ord7");

    // Random frac at third order: range and one-period sum (frac + e1, e1 in -1..2).
    for (int r = 0; r < 3; r++) begin
      f = $urandom_range(1, 255);
      restart(8'(f), 4'd8, 3'd3, 1'b0);
      sum = 0;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        @(posedge i_clk);
        #1;
        if (dsm_s() < -3 || dsm_s() > 4 || o_valid !== 1'b1) bad++;
        sum += dsm_s();
      end
      check("k3_range_bad", bad, 0);
      check("k3_sum_in_band", int'(sum >= int'(f) - 1 && sum <= int'(f) + 2), 1);
    end

    // Zero input, third order: output stays 0.
    restart(8'd0, 4'd8, 3'd3, 1'b0);
    nz = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge i_clk);
      #1;
      if (dsm_s() != 0) nz++;
    end
    check("k3_zero_nonzero", nz, 0);

    // Seed load with i_en high, taken right after a 1 output.
    restart(8'd128, 4'd8, 3'd1, 1'b0);
    exp_seq = {0, 1};
    run_expect("pre_seed");
    @(negedge i_clk);
    i_seed_load = 1'b1;
    i_seed      = 8'h80;
    @(posedge i_clk);
    #1;
    check("seed_valid", int'(o_valid), 0);
    check("seed_dsm", dsm_s(), 0);
    @(negedge i_clk);
    i_seed_load = 1'b0;
    exp_seq = {1, 0};
    run_expect("post_seed");

    // Asynchronous reset between edges, then a clean rerun of the first pattern.
    restart(8'd64, 4'd8, 3'd1, 1'b0);
    exp_seq = {0, 0, 0, 1};
    run_expect("pre_arst");
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("arst_dsm", dsm_s(), 0);
    check("arst_valid", int'(o_valid), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_seq = {0, 0, 0, 1, 0, 0, 0, 1};
    run_expect("post_arst");

    // Dither from LFSR 0xACE1 with frac=255: carry-ins 1,0,0,0 -> outputs 1,0,1,1.
    restart(8'd255, 4'd8, 3'd1, 1'b1);
    exp_seq = {1, 0, 1, 1};
    run_expect("dither");

    @(negedge i_clk);
    i_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
